// File: rtl/alu_seq32.sv
// alu_seq32: 32-bit ADD/SUB/logic ALU that runs one 8-bit ALU over the four operand bytes, LSB first.
// Build option: define ALU_SEQ32_CARRY_IN_EN to use _iC as the ADD/SUB carry/borrow-in; otherwise _iC is ignored.

package cpu_pkg;
  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    NOR  = 3'd2,
    NAND = 3'd3,
    XOR  = 3'd4,
    XNOR = 3'd5
  } Operation;
endpackage

module alu8
  import cpu_pkg::*;
(
  input  Operation   op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero
);

  logic [8:0] wide_s;

  // Byte-wide function; for SUB the carry output is the borrow out of bit 7.
  always_comb begin
    wide_s = 9'd0;
    result = 8'd0;
    carry  = 1'b0;
    case (op)
      ADD: begin
        wide_s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        result = wide_s[7:0];
        carry  = wide_s[8];
      end
      SUB: begin
        wide_s = {1'b0, a} - {1'b0, b} - {8'd0, cin};
        result = wide_s[7:0];
        carry  = wide_s[8];
      end
      NOR:     result = ~(a | b);
      NAND:    result = ~(a & b);
      XOR:     result = a ^ b;
      XNOR:    result = ~(a ^ b);
      default: begin
        result = 8'd0;
        carry  = 1'b0;
      end
    endcase
    zero = (result == 8'd0);
  end

endmodule

module alu_seq32
  import cpu_pkg::*;
(
  input  logic        _iClk,
  input  logic        _iNReset,
  input  logic        _iValid,
  output logic        _oReady,
  input  Operation    _iOp,
  input  logic [31:0] _iA,
  input  logic [31:0] _iB,
  input  logic        _iC,
  output logic        _oDone,
  output logic [31:0] _oResult,
  output logic        _oFlagCarry,
  output logic        _oFlagZero,
  output logic        _oFlagNeg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } SeqState;

  SeqState     state_r;
  SeqState     nextState_s;
  logic        accept_s;
  logic        step_s;
  logic        last_s;
  logic        cinEff_s;

  logic [1:0]  byteIdx_r;
  Operation    op_r;
  logic [31:0] opA_r;
  logic [31:0] opB_r;
  logic        carryChain_r;
  logic [31:0] resAcc_r;
  logic        zeroAcc_r;

  logic [31:0] result_r;
  logic        flagCarry_r;
  logic        flagZero_r;
  logic        flagNeg_r;
  logic        done_r;
  logic        ready_r;

  logic [7:0]  byteA_s;
  logic [7:0]  byteB_s;
  logic [7:0]  aluRes_s;
  logic        aluCarry_s;
  logic        aluZero_s;

  // Byte-0 carry-in captured at accept; without the build option the port is kept but its value is dropped.
  always_comb begin
`ifdef ALU_SEQ32_CARRY_IN_EN
    if ((_iOp == ADD) || (_iOp == SUB)) begin
      cinEff_s = _iC;
    end else begin
      cinEff_s = 1'b0;
    end
`else
    cinEff_s = 1'b0 & _iC;
`endif
  end

  // Next-state decode and per-cycle datapath controls.
  always_comb begin
    nextState_s = state_r;
    accept_s    = 1'b0;
    step_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (_iValid) begin
          accept_s    = 1'b1;
          nextState_s = RUN;
        end else begin
          nextState_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (byteIdx_r == 2'd3) begin
          last_s      = 1'b1;
          nextState_s = DONE;
        end else begin
          nextState_s = RUN;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // State register plus registered handshake outputs derived from the next state.
  always_ff @(posedge _iClk) begin
    if (!_iNReset) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= nextState_s;
      ready_r <= (nextState_s != RUN);
      done_r  <= (nextState_s == DONE);
    end
  end

  assign byteA_s = opA_r[{byteIdx_r, 3'b000} +: 8];
  assign byteB_s = opB_r[{byteIdx_r, 3'b000} +: 8];

  alu8 uAlu8 (
    .op     (op_r),
    .a      (byteA_s),
    .b      (byteB_s),
    .cin    (carryChain_r),
    .result (aluRes_s),
    .carry  (aluCarry_s),
    .zero   (aluZero_s)
  );

  // Operand capture, byte sequencing and the final result/flag update on the last byte.
  always_ff @(posedge _iClk) begin
    if (!_iNReset) begin
      byteIdx_r    <= 2'd0;
      op_r         <= ADD;
      opA_r        <= 32'd0;
      opB_r        <= 32'd0;
      carryChain_r <= 1'b0;
      resAcc_r     <= 32'd0;
      zeroAcc_r    <= 1'b1;
      result_r     <= 32'd0;
      flagCarry_r  <= 1'b0;
      flagZero_r   <= 1'b0;
      flagNeg_r    <= 1'b0;
    end else if (accept_s) begin
      byteIdx_r    <= 2'd0;
      op_r         <= _iOp;
      opA_r        <= _iA;
      opB_r        <= _iB;
      carryChain_r <= cinEff_s;
      resAcc_r     <= 32'd0;
      zeroAcc_r    <= 1'b1;
    end else if (step_s) begin
      resAcc_r[{byteIdx_r, 3'b000} +: 8] <= aluRes_s;
      zeroAcc_r    <= zeroAcc_r & aluZero_s;
      carryChain_r <= aluCarry_s;
      byteIdx_r    <= byteIdx_r + 2'd1;
      if (last_s) begin
        // Byte 3 is taken straight from the ALU so the outputs land on the same edge.
        result_r    <= {aluRes_s, resAcc_r[23:0]};
        flagCarry_r <= aluCarry_s;
        flagNeg_r   <= aluRes_s[7];
        flagZero_r  <= zeroAcc_r & aluZero_s;
      end
    end
  end

  assign _oReady     = ready_r;
  assign _oDone      = done_r;
  assign _oResult    = result_r;
  assign _oFlagCarry = flagCarry_r;
  assign _oFlagZero  = flagZero_r;
  assign _oFlagNeg   = flagNeg_r;

endmodule

// File: tb/tb_alu_seq32.sv
// Self-checking bench for alu_seq32: directed vectors, randomized operations against a 32-bit
// arithmetic reference model, back-to-back issue and reset behaviour.
module tb_alu_seq32;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        nReset;
  logic        valid;
  logic        ready;
  Operation    op;
  logic [31:0] a;
  logic [31:0] b;
  logic        c;
  logic        done;
  logic [31:0] result;
  logic        flagCarry;
  logic        flagZero;
  logic        flagNeg;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [34:0] prev;   // last completed {result, carry, zero, neg}

  alu_seq32 dut (
    ._iClk       (clk),
    ._iNReset    (nReset),
    ._iValid     (valid),
    ._oReady     (ready),
    ._iOp        (op),
    ._iA         (a),
    ._iB         (b),
    ._iC         (c),
    ._oDone      (done),
    ._oResult    (result),
    ._oFlagCarry (flagCarry),
    ._oFlagZero  (flagZero),
    ._oFlagNeg   (flagNeg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [34:0] refModel(input Operation o, input logic [31:0] x,
                                           input logic [31:0] y, input logic ci);
    logic [32:0] full;
    logic [31:0] r;
    logic        cy;
    logic        cinEff;
`ifdef ALU_SEQ32_CARRY_IN_EN
    cinEff = ci;
`else
    cinEff = 1'b0 & ci;
`endif
    full = 33'd0;
    r    = 32'd0;
    cy   = 1'b0;
    case (o)
      ADD: begin
        full = {1'b0, x} + {1'b0, y} + {32'd0, cinEff};
        r = full[31:0];
        cy = full[32];
      end
      SUB: begin
        full = {1'b0, x} - {1'b0, y} - {32'd0, cinEff};
        r = full[31:0];
        cy = full[32];
      end
      NOR:     r = ~(x | y);
      NAND:    r = ~(x & y);
      XOR:     r = x ^ y;
      XNOR:    r = ~(x ^ y);
      default: r = 32'd0;
    endcase
    return {r, cy, (r == 32'd0), r[31]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scrambleInputs();
    logic [2:0] t;
    t  = 3'($urandom_range(0, 7));
    op = Operation'(t);
    a  = $urandom;
    b  = $urandom;
    c  = 1'($urandom_range(0, 1));
  endtask

  // Issue one operation, scramble the inputs after accept, check hold during RUN and the DONE cycle.
  task automatic runOp(input Operation o, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input bit chain, output int doneCyc);
    logic [34:0] expv;
    int wt;
    expv = refModel(o, x, y, ci);
    wt = 0;
    while (ready !== 1'b1 && wt < 20) begin
      tick();
      wt++;
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_wait: ready=%b required=1", ready);
    end
    valid = 1'b1;
    op = o;
    a = x;
    b = y;
    c = ci;
    tick();
    valid = 1'b0;
    scrambleInputs();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({done, ready, result, flagCarry, flagZero, flagNeg} !== {2'b00, prev}) begin
        failures++;
        $display("FAIL run_hold k=%0d: done=%b ready=%b res=%h CZN=%b%b%b required done=0 ready=0 res=%h CZN=%b",
                 k, done, ready, result, flagCarry, flagZero, flagNeg, prev[34:3], prev[2:0]);
      end
      tick();
    end
    doneCyc = cyc;
    checks++;
    if ({done, ready, result, flagCarry, flagZero, flagNeg} !== {2'b11, expv}) begin
      failures++;
      $display("FAIL op_result op=%0d a=%h b=%h c=%b: done=%b ready=%b res=%h CZN=%b%b%b required done=1 ready=1 res=%h CZN=%b",
               o, x, y, ci, done, ready, result, flagCarry, flagZero, flagNeg, expv[34:3], expv[2:0]);
    end
    prev = expv;
    if (!chain) begin
      tick();
      checks++;
      if ({done, ready} !== 2'b01) begin
        failures++;
        $display("FAIL done_pulse: done=%b ready=%b required done=0 ready=1", done, ready);
      end
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    valid = 1'b1;
    op = ADD;
    a = 32'h1;
    b = 32'h1;
    c = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ready, done, result, flagCarry, flagZero, flagNeg} !== {1'b1, 1'b0, 35'd0}) begin
      failures++;
      $display("FAIL reset_state: ready=%b done=%b res=%h CZN=%b%b%b required ready=1 done=0 res=0 CZN=000",
               ready, done, result, flagCarry, flagZero, flagNeg);
    end
    valid = 1'b0;
    nReset = 1'b1;
    tick();
    checks++;
    if ({ready, done} !== 2'b10) begin
      failures++;
      $display("FAIL reset_no_accept: ready=%b done=%b required ready=1 done=0", ready, done);
    end
    prev = 35'd0;
  endtask

  task automatic test_idle_hold();
    for (int k = 0; k < 5; k++) begin
      scrambleInputs();
      tick();
      checks++;
      if ({done, ready, result, flagCarry, flagZero, flagNeg} !== {2'b01, prev}) begin
        failures++;
        $display("FAIL idle_hold k=%0d: done=%b ready=%b res=%h required done=0 ready=1 res=%h",
                 k, done, ready, result, prev[34:3]);
      end
    end
  endtask

  task automatic test_directed();
    int d;
    runOp(ADD,  32'h000000FF, 32'h00000001, 1'b0, 1'b0, d);
    runOp(ADD,  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, d);
    runOp(SUB,  32'h00000000, 32'h00000001, 1'b0, 1'b0, d);
    runOp(XOR,  32'h12345678, 32'h12345678, 1'b1, 1'b0, d);
    runOp(ADD,  32'h00000000, 32'h00000000, 1'b1, 1'b0, d);
    runOp(SUB,  32'h00000100, 32'h00000001, 1'b1, 1'b0, d);
    runOp(NOR,  32'h0F0F0000, 32'h00F0F000, 1'b1, 1'b0, d);
    runOp(NAND, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0, d);
    runOp(XNOR, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, d);
    runOp(Operation'(3'd6), 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0, d);
    runOp(Operation'(3'd7), 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, d);
  endtask

  task automatic test_random();
    int d;
    logic [2:0] t;
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 40; i++) begin
      t = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      runOp(Operation'(t), x, y, 1'($urandom_range(0, 1)), 1'b0, d);
    end
  endtask

  task automatic test_back_to_back();
    int d1;
    int d2;
    runOp(SUB, 32'h00001000, 32'h00000FFF, 1'b0, 1'b1, d1);
    runOp(ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, d2);
    checks++;
    if (d2 - d1 !== 5) begin
      failures++;
      $display("FAIL back_to_back_spacing: cycles=%0d required=5", d2 - d1);
    end
    d1 = d2;
    runOp(XOR, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, d2);
    checks++;
    if (d2 - d1 !== 5) begin
      failures++;
      $display("FAIL back_to_back_spacing2: cycles=%0d required=5", d2 - d1);
    end
  endtask

  task automatic test_reset_inflight();
    int d;
    bit sawDone;
    runOp(ADD, 32'h00000005, 32'h00000006, 1'b0, 1'b0, d);
    valid = 1'b1;
    op = SUB;
    a = $urandom;
    b = $urandom;
    tick();
    valid = 1'b0;
    tick();
    tick();
    nReset = 1'b0;
    #2;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_sync: ready=%b required=0 before the reset edge", ready);
    end
    tick();
    checks++;
    if ({ready, done, result, flagCarry, flagZero, flagNeg} !== {1'b1, 1'b0, 35'd0}) begin
      failures++;
      $display("FAIL reset_inflight: ready=%b done=%b res=%h CZN=%b%b%b required ready=1 done=0 res=0 CZN=000",
               ready, done, result, flagCarry, flagZero, flagNeg);
    end
    nReset = 1'b1;
    prev = 35'd0;
    sawDone = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done === 1'b1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard: done pulse seen=%b required=0", sawDone);
    end
    runOp(ADD, 32'h80000000, 32'h80000000, 1'b0, 1'b0, d);
  endtask

  initial begin
    nReset = 1'b0;
    valid = 1'b0;
    op = ADD;
    a = 32'd0;
    b = 32'd0;
    c = 1'b0;
    prev = 35'd0;
    test_reset();
    test_idle_hold();
    test_directed();
    test_random();
    test_back_to_back();
    test_idle_hold();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
